// File: rtl/pxl_tx_pkg.sv
// pxl_tx_pkg: shared types, defaults and width helper for pixel_gpio_tx.
package pxl_tx_pkg;
  typedef enum logic {IDLE, WAIT_ACK} state_e;
  localparam int FRAME_BYTES_DEF = 12288;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pxl_tx_fifo.sv
// pxl_tx_fifo: synchronous byte FIFO with registered occupancy and head read-out.
module pxl_tx_fifo
  import pxl_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = lvl_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    dat_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic [LW-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  assign level_d = level_q + LW'(push_i) - LW'(pop_i);
  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q] <= dat_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/pixel_gpio_tx.sv
// pixel_gpio_tx: pixel stream to GPIO toggle req/ack bridge with frame EOF flag.
// Optional odd parity output enabled by defining PXL_TX_PARITY_EN.
module pixel_gpio_tx
  import pxl_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [7:0]                   pxl_dat_i,
  input  logic                         pxl_vld_i,
  output logic                         pxl_rdy_o,
  output logic [7:0]                   gpio_dat_o,
  output logic                         gpio_req_o,
  input  logic                         gpio_ack_i,
  output logic                         gpio_eof_o,
  output logic                         gpio_par_o,
  output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level_o,
  output logic                         frame_done_o
);
  localparam int LW = lvl_w(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_BYTES);
  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q;
  logic                   req_q, eof_q, done_q;
  logic [7:0]             dat_q, head;
  logic [CW-1:0]          cnt_q;
  logic [LW-1:0]          level;
  logic                   ack_s, hs_done, push, pop, last;
  assign ack_s     = sync_q[SYNC_STAGES-1];
  assign hs_done   = state_q == WAIT_ACK && ack_s == req_q;
  assign pop       = level != '0 && (state_q == IDLE || hs_done);
  assign pxl_rdy_o = level != LW'(FIFO_DEPTH);
  assign push      = pxl_vld_i && pxl_rdy_o;
  assign last      = cnt_q == CW'(FRAME_BYTES - 1);
  pxl_tx_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .push_i (push),
    .dat_i  (pxl_dat_i),
    .pop_i  (pop),
    .head_o (head),
    .level_o(level)
  );
  // A completed handshake with data waiting relaunches in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q  <= '0;
      state_q <= IDLE;
      req_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_ack_i};
      done_q <= hs_done && eof_q;
      if (pop) begin
        dat_q   <= head;
        eof_q   <= last;
        req_q   <= ~req_q;
        cnt_q   <= last ? '0 : cnt_q + 1'b1;
        state_q <= WAIT_ACK;
      end else if (hs_done) state_q <= IDLE;
    end
  end
`ifdef PXL_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) par_q <= 1'b0;
    else if (pop) par_q <= ~^head;
  assign gpio_par_o = par_q;
`else
  assign gpio_par_o = 1'b0;
`endif
  assign gpio_dat_o   = dat_q;
  assign gpio_req_o   = req_q;
  assign gpio_eof_o   = eof_q;
  assign fifo_level_o = level;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_pixel_gpio_tx.sv
// tb_pixel_gpio_tx: directed checks of pixel_gpio_tx with FRAME_BYTES=4 and a bench-driven host.
module tb_pixel_gpio_tx;
  logic       clk = 1'b0, rst = 1'b1, vld = 1'b0, ack = 1'b0;
  logic [7:0] dat = '0;
  logic       rdy, req, eof, par, done;
  logic [7:0] gdat;
  logic [2:0] level;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pixel_gpio_tx #(.FIFO_DEPTH(4), .FRAME_BYTES(4), .SYNC_STAGES(2)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .pxl_dat_i   (dat),
    .pxl_vld_i   (vld),
    .pxl_rdy_o   (rdy),
    .gpio_dat_o  (gdat),
    .gpio_req_o  (req),
    .gpio_ack_i  (ack),
    .gpio_eof_o  (eof),
    .gpio_par_o  (par),
    .fifo_level_o(level),
    .frame_done_o(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic exp_par(input logic [7:0] d);
`ifdef PXL_TX_PARITY_EN
    return ~^d;
`else
    return 1'b0;
`endif
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_byte(input logic [7:0] d);
    vld = 1'b1;
    dat = d;
    step(1);
    vld = 1'b0;
  endtask
  task automatic rst_dut();
    rst = 1'b1;
    vld = 1'b0;
    ack = 1'b0;
    step(1);
    check("rst_req", req, 0);
    check("rst_dat", gdat, 0);
    check("rst_eof", eof, 0);
    check("rst_par", par, 0);
    check("rst_done", done, 0);
    check("rst_level", level, 0);
    check("rst_rdy", rdy, 1);
    rst = 1'b0;
  endtask
  initial begin
    int launches, dones, p, last_t;
    logic prev_req;
    step(1);
    rst_dut();
    // single byte
    push_byte(8'hA5);
    check("sb_level_in", level, 1);
    check("sb_req_pre", req, 0);
    step(1);
    check("sb_dat", gdat, 8'hA5);
    check("sb_req", req, 1);
    check("sb_level", level, 0);
    check("sb_eof", eof, 0);
    check("sb_par", par, exp_par(8'hA5));
    step(4);
    ack = 1'b1;
    step(3);
    check("sb_req_hold", req, 1);
    check("sb_done", done, 0);
    push_byte(8'h5A);
    step(1);
    check("sb_idle_dat", gdat, 8'h5A);
    check("sb_idle_req", req, 0);
    // backpressure
    rst_dut();
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check("bp_level", level, 4);
    check("bp_rdy", rdy, 0);
    check("bp_dat", gdat, 8'h10);
    check("bp_req", req, 1);
    vld = 1'b1;
    dat = 8'h99;
    step(1);
    vld = 1'b0;
    check("bp_nofill", level, 4);
    for (int k = 1; k <= 4; k++) begin
      ack = ~ack;
      step(2);
      check("bp_hold", gdat, 8'h10 + 8'(k - 1));
      step(1);
      check("bp_drain_dat", gdat, 8'h10 + 8'(k));
      check("bp_drain_req", req, (k % 2) == 0);
      check("bp_drain_eof", eof, k == 3);
      check("bp_drain_done", done, k == 4);
      if (k == 1) check("bp_rdy_back", rdy, 1);
    end
    ack = ~ack;
    step(3);
    check("bp_empty", level, 0);
    check("bp_last_done", done, 0);
    check("bp_last_req", req, 1);
    // frame boundary and back-to-back spacing with an immediate-ack host
    rst_dut();
    launches = 0;
    dones = 0;
    p = 0;
    last_t = 0;
    prev_req = req;
    for (int c = 0; c < 80; c++) begin
      if (req != prev_req) begin
        check("frm_dat", gdat, 32'h20 + launches);
        check("frm_eof", eof, (launches % 4) == 3);
        if (launches > 0) check("frm_gap", c - last_t, 3);
        last_t = c;
        launches++;
        prev_req = req;
      end
      if (done) dones++;
      ack = req;
      if (p < 8 && rdy) begin
        vld = 1'b1;
        dat = 8'h20 + 8'(p);
        p++;
      end else vld = 1'b0;
      step(1);
    end
    check("frm_launches", launches, 8);
    check("frm_dones", dones, 2);
    // reset mid-transfer, then parity
    rst_dut();
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
    ack = ~ack;
    step(3);
    ack = ~ack;
    step(3);
    check("mr_pre_dat", gdat, 8'h32);
    for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
    check("mr_level", level, 3);
    rst_dut();
    push_byte(8'h07);
    push_byte(8'h03);
    check("mr_dat", gdat, 8'h07);
    check("mr_eof", eof, 0);
    check("mr_req", req, 1);
    check("par_07", par, exp_par(8'h07));
    ack = 1'b1;
    step(3);
    check("par_dat", gdat, 8'h03);
    check("par_03", par, exp_par(8'h03));
    check("par_eof", eof, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
